// File: rtl/wb_trace_sink.sv
// Writeback-trace sink: buffers retired register writes and streams them out as 10-byte 0xA5-framed records.
// Optional macro WB_TRACE_FILTER_X0_EN: when defined, writes to x0 are not captured.
module wb_trace_sink #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     debug_wb_have_inst,
    input  logic [31:0]              debug_wb_pc,
    input  logic                     debug_wb_ena,
    input  logic [4:0]               debug_wb_reg,
    input  logic [31:0]              debug_wb_value,
    input  logic                     capture_en,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [71:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [0:0]    state;
    logic [3:0]    idx;
    logic [71:0]   hold;

    logic          capture;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [71:0]   record;

`ifdef WB_TRACE_FILTER_X0_EN
    assign capture = capture_en & debug_wb_have_inst & debug_wb_ena & (debug_wb_reg != 5'd0);
`else
    assign capture = capture_en & debug_wb_have_inst & debug_wb_ena;
`endif

    assign record = {debug_wb_pc, 3'b000, debug_wb_reg, debug_wb_value};
    assign full   = (count == CW'(DEPTH));
    assign pop    = (state == ST_IDLE) && (count != '0);
    // A pop on the same edge frees a slot, so a full FIFO still accepts the new record.
    assign push   = capture && (!full || pop);
    assign drop   = capture && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= record;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= ST_IDLE;
            idx        <= 4'd0;
            hold       <= '0;
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end

            if (state == ST_IDLE) begin
                if (pop) begin
                    hold  <= mem[rd_ptr];
                    idx   <= 4'd0;
                    state <= ST_SEND;
                end
            end else begin
                if (tx_ready) begin
                    if (idx == 4'd9) begin
                        idx   <= 4'd0;
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
            end
        end
    end

    // Byte select is decoded from registered state only, so tx_ready never reaches tx_data.
    always_comb begin
        tx_data = 8'h00;
        if (state == ST_SEND) begin
            case (idx)
                4'd0:    tx_data = 8'hA5;
                4'd1:    tx_data = hold[71:64];
                4'd2:    tx_data = hold[63:56];
                4'd3:    tx_data = hold[55:48];
                4'd4:    tx_data = hold[47:40];
                4'd5:    tx_data = hold[39:32];
                4'd6:    tx_data = hold[31:24];
                4'd7:    tx_data = hold[23:16];
                4'd8:    tx_data = hold[15:8];
                4'd9:    tx_data = hold[7:0];
                default: tx_data = 8'h00;
            endcase
        end
    end

    assign tx_valid   = (state == ST_SEND);
    assign fifo_count = count;

endmodule

// File: tb/tb_wb_trace_sink.sv
// Self-checking bench for wb_trace_sink: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_trace_sink;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          debug_wb_have_inst;
    logic [31:0]   debug_wb_pc;
    logic          debug_wb_ena;
    logic [4:0]    debug_wb_reg;
    logic [31:0]   debug_wb_value;
    logic          capture_en;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [15:0]   drop_count;

    int tests = 0;
    int fails = 0;

    wb_trace_sink #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .debug_wb_have_inst (debug_wb_have_inst),
        .debug_wb_pc        (debug_wb_pc),
        .debug_wb_ena       (debug_wb_ena),
        .debug_wb_reg       (debug_wb_reg),
        .debug_wb_value     (debug_wb_value),
        .capture_en         (capture_en),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .fifo_count         (fifo_count),
        .overflow           (overflow),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: records waiting, plus the bytes still owed for the frame in flight.
    logic [71:0] m_q [$];
    logic [7:0]  m_bytes [$];
    bit          m_busy = 1'b0;
    bit          m_ovf = 1'b0;
    int          m_drops = 0;

    function automatic logic [71:0] make_rec(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] v);
        return {pc, 3'b000, r, v};
    endfunction

    function automatic logic [7:0] frame_byte(input logic [71:0] rec, input int b);
        if (b == 0) return 8'hA5;
        return rec[79 - 8*b -: 8];
    endfunction

    always @(posedge clk) begin
        bit          cap;
        bit          was_full;
        bit          do_pop;
        logic [71:0] rec;
        if (rst) begin
            m_q.delete();
            m_bytes.delete();
            m_busy  = 1'b0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            cap = capture_en && debug_wb_have_inst && debug_wb_ena;
`ifdef WB_TRACE_FILTER_X0_EN
            cap = cap && (debug_wb_reg != 5'd0);
`endif
            was_full = (m_q.size() == DEPTH);
            do_pop   = !m_busy && (m_q.size() != 0);
            if (m_busy && tx_ready) begin
                void'(m_bytes.pop_front());
                if (m_bytes.size() == 0) m_busy = 1'b0;
            end
            if (do_pop) begin
                rec = m_q.pop_front();
                for (int b = 0; b < 10; b++) m_bytes.push_back(frame_byte(rec, b));
                m_busy = 1'b1;
            end
            if (cap) begin
                if (!was_full || do_pop) begin
                    m_q.push_back(make_rec(debug_wb_pc, debug_wb_reg, debug_wb_value));
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        debug_wb_have_inst = 1'b0;
        debug_wb_ena       = 1'b0;
        debug_wb_pc        = 32'd0;
        debug_wb_reg       = 5'd0;
        debug_wb_value     = 32'd0;
        capture_en         = 1'b1;
    endtask

    task automatic set_event(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] v);
        debug_wb_have_inst = 1'b1;
        debug_wb_ena       = 1'b1;
        debug_wb_pc        = pc;
        debug_wb_reg       = r;
        debug_wb_value     = v;
    endtask

    task automatic do_reset();
        idle_inputs();
        tx_ready = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_drain(input string name);
        logic [7:0] exp_data;
        idle_inputs();
        tx_ready = 1'b1;
        for (int c = 0; c < DEPTH * 11 + 40; c++) begin
            if (!m_busy && m_q.size() == 0) break;
            cycle();
            exp_data = m_busy ? m_bytes[0] : 8'h00;
            tests++;
            if ({tx_valid, tx_data} !== {m_busy, exp_data} || int'(fifo_count) !== m_q.size()) begin
                fails++;
                $display("[TB] FAIL %s_stream got v=%0b d=%02h cnt=%0d want v=%0b d=%02h cnt=%0d",
                         name, tx_valid, tx_data, fifo_count, m_busy, exp_data, m_q.size());
            end
        end
        tests++;
        if (tx_valid !== 1'b0 || fifo_count !== '0) begin
            fails++;
            $display("[TB] FAIL %s_end got v=%0b cnt=%0d want v=0 cnt=0", name, tx_valid, fifo_count);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        tx_ready = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        tests++;
        if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_tx_valid got %0b want 0", tx_valid); end
        tests++;
        if (tx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_tx_data got %02h want 00", tx_data); end
        tests++;
        if (fifo_count !== '0) begin fails++; $display("[TB] FAIL reset_fifo_count got %0d want 0", fifo_count); end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow got %0b want 0", overflow); end
        tests++;
        if (drop_count !== 16'd0) begin fails++; $display("[TB] FAIL reset_drop_count got %0d want 0", drop_count); end
        rst = 1'b0;
    endtask

    task automatic test_single_event();
        logic [7:0] exp_b [10];
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_reset();
        tx_ready = 1'b1;
        set_event(32'h0000_0010, 5'd5, 32'hDEAD_BEEF);
        cycle();
        idle_inputs();
        tests++;
        if ({tx_valid, fifo_count} !== {1'b0, CW'(1)}) begin
            fails++;
            $display("[TB] FAIL single_capture got v=%0b cnt=%0d want v=0 cnt=1", tx_valid, fifo_count);
        end
        cycle();
        tests++;
        if (fifo_count !== '0) begin fails++; $display("[TB] FAIL single_pop_count got %0d want 0", fifo_count); end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if ({tx_valid, tx_data} !== {1'b1, exp_b[i]}) begin
                fails++;
                $display("[TB] FAIL single_byte%0d got v=%0b d=%02h want v=1 d=%02h", i, tx_valid, tx_data, exp_b[i]);
            end
            cycle();
        end
        tests++;
        if ({tx_valid, fifo_count} !== {1'b0, CW'(0)}) begin
            fails++;
            $display("[TB] FAIL single_end got v=%0b cnt=%0d want v=0 cnt=0", tx_valid, fifo_count);
        end
    endtask

    task automatic test_backpressure();
        logic [71:0] rec;
        logic [31:0] v;
        v = $urandom;
        rec = make_rec(32'h0000_0100, 5'd3, v);
        do_reset();
        tx_ready = 1'b1;
        set_event(32'h0000_0100, 5'd3, v);
        cycle();
        idle_inputs();
        cycle();
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 4) begin
                tx_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    cycle();
                    tests++;
                    if ({tx_valid, tx_data} !== {1'b1, frame_byte(rec, i)}) begin
                        fails++;
                        $display("[TB] FAIL bp_hold%0d got v=%0b d=%02h want v=1 d=%02h", i, tx_valid, tx_data, frame_byte(rec, i));
                    end
                end
                tx_ready = 1'b1;
            end
            tests++;
            if ({tx_valid, tx_data} !== {1'b1, frame_byte(rec, i)}) begin
                fails++;
                $display("[TB] FAIL bp_byte%0d got v=%0b d=%02h want v=1 d=%02h", i, tx_valid, tx_data, frame_byte(rec, i));
            end
            cycle();
        end
        tests++;
        if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_end got v=%0b want 0", tx_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] pcs [20];
        logic [31:0] vals [20];
        logic [4:0]  regs [20];
        logic [7:0]  got [$];
        int          bad;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pcs[i]  = 32'h0000_1000 + 32'(4 * i);
            vals[i] = $urandom;
            regs[i] = 5'(i + 1);
            set_event(pcs[i], regs[i], vals[i]);
            cycle();
        end
        idle_inputs();
        tests++;
        if (fifo_count !== CW'(16)) begin fails++; $display("[TB] FAIL ovf_count got %0d want 16", fifo_count); end
        tests++;
        if (drop_count !== 16'd3) begin fails++; $display("[TB] FAIL ovf_drops got %0d want 3", drop_count); end
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_flag got %0b want 1", overflow); end
        tx_ready = 1'b1;
        for (int c = 0; c < 400 && got.size() < 170; c++) begin
            if (tx_valid) got.push_back(tx_data);
            cycle();
        end
        tests++;
        if (got.size() != 170) begin
            fails++;
            $display("[TB] FAIL ovf_drain_len got %0d want 170", got.size());
        end else begin
            for (int r = 0; r < 17; r++) begin
                bad = 0;
                for (int b = 0; b < 10; b++)
                    if (got[r*10 + b] !== frame_byte(make_rec(pcs[r], regs[r], vals[r]), b)) bad++;
                tests++;
                if (bad != 0) begin
                    fails++;
                    $display("[TB] FAIL ovf_frame%0d got pc=%02h%02h%02h%02h want pc=%08h", r,
                             got[r*10+1], got[r*10+2], got[r*10+3], got[r*10+4], pcs[r]);
                end
            end
        end
        tests++;
        if ({fifo_count, drop_count} !== {CW'(0), 16'd3}) begin
            fails++;
            $display("[TB] FAIL ovf_after got cnt=%0d drops=%0d want cnt=0 drops=3", fifo_count, drop_count);
        end
    endtask

    task automatic test_full_pop();
        int n;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_event(32'h0000_2000 + 32'(4 * i), 5'd7, 32'(i));
            cycle();
        end
        idle_inputs();
        tests++;
        if (fifo_count !== CW'(16)) begin fails++; $display("[TB] FAIL fullpop_prefill got %0d want 16", fifo_count); end
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 20) begin
            cycle();
            n++;
        end
        tests++;
        if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL fullpop_wait got v=%0b want 0", tx_valid); end
        set_event(32'h0000_2FFC, 5'd9, 32'hCAFE_F00D);
        cycle();
        idle_inputs();
        tests++;
        if ({fifo_count, drop_count, overflow, tx_valid, tx_data} !== {CW'(16), 16'd0, 1'b0, 1'b1, 8'hA5}) begin
            fails++;
            $display("[TB] FAIL fullpop_edge got cnt=%0d drops=%0d ovf=%0b v=%0b d=%02h want cnt=16 drops=0 ovf=0 v=1 d=a5",
                     fifo_count, drop_count, overflow, tx_valid, tx_data);
        end
        test_drain("fullpop");
    endtask

    task automatic test_gating();
        int exp_x0;
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_event($urandom, 5'd1 + 5'($urandom_range(0, 30)), $urandom);
            if (i < 10) capture_en = 1'b0;
            else        debug_wb_ena = 1'b0;
            cycle();
            tests++;
            if ({tx_valid, fifo_count} !== {1'b0, CW'(0)}) begin
                fails++;
                $display("[TB] FAIL gate%0d got v=%0b cnt=%0d want v=0 cnt=0", i, tx_valid, fifo_count);
            end
        end
`ifdef WB_TRACE_FILTER_X0_EN
        exp_x0 = 0;
`else
        exp_x0 = 1;
`endif
        idle_inputs();
        set_event(32'h0000_3000, 5'd0, 32'h1234_5678);
        cycle();
        idle_inputs();
        tests++;
        if (int'(fifo_count) !== exp_x0) begin
            fails++;
            $display("[TB] FAIL gate_x0 got cnt=%0d want %0d", fifo_count, exp_x0);
        end
        test_drain("gate");
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v0;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) v0 = 32'h8765_4321;
            set_event(32'h0000_4000 + 32'(4 * i), 5'd2, (i == 0) ? v0 : $urandom);
            cycle();
        end
        idle_inputs();
        tx_ready = 1'b1;
        repeat (6) cycle();
        tests++;
        if ({tx_valid, tx_data} !== {1'b1, v0[31:24]}) begin
            fails++;
            $display("[TB] FAIL rstmid_idx6 got v=%0b d=%02h want v=1 d=%02h", tx_valid, tx_data, v0[31:24]);
        end
        rst = 1'b1;
        set_event(32'h0000_5000, 5'd4, 32'h0BAD_0BAD);
        cycle();
        rst = 1'b0;
        idle_inputs();
        tests++;
        if ({tx_valid, fifo_count, overflow, drop_count} !== {1'b0, CW'(0), 1'b0, 16'd0}) begin
            fails++;
            $display("[TB] FAIL rstmid_after got v=%0b cnt=%0d ovf=%0b drops=%0d want 0 0 0 0",
                     tx_valid, fifo_count, overflow, drop_count);
        end
        set_event(32'h0000_6000, 5'd6, 32'h0000_0066);
        cycle();
        idle_inputs();
        cycle();
        tests++;
        if ({tx_valid, tx_data} !== {1'b1, 8'hA5}) begin
            fails++;
            $display("[TB] FAIL rstmid_restart got v=%0b d=%02h want v=1 d=a5", tx_valid, tx_data);
        end
        test_drain("rstmid");
    endtask

    task automatic test_random(input int n);
        logic [7:0] exp_data;
        do_reset();
        for (int c = 0; c < n; c++) begin
            rst                = ($urandom_range(0, 299) == 0);
            capture_en         = ($urandom_range(0, 9) < 8);
            debug_wb_have_inst = ($urandom_range(0, 1) == 1);
            debug_wb_ena       = ($urandom_range(0, 9) < 7);
            debug_wb_pc        = $urandom;
            debug_wb_reg       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            debug_wb_value     = $urandom;
            tx_ready           = ($urandom_range(0, 9) < 7);
            cycle();
            exp_data = m_busy ? m_bytes[0] : 8'h00;
            tests++;
            if ({tx_valid, tx_data} !== {m_busy, exp_data} || int'(fifo_count) !== m_q.size() ||
                overflow !== m_ovf || int'(drop_count) !== m_drops) begin
                fails++;
                $display("[TB] FAIL rand_c%0d got v=%0b d=%02h cnt=%0d ovf=%0b drops=%0d want v=%0b d=%02h cnt=%0d ovf=%0b drops=%0d",
                         c, tx_valid, tx_data, fifo_count, overflow, drop_count,
                         m_busy, exp_data, m_q.size(), m_ovf, m_drops);
            end
        end
        rst = 1'b0;
        test_drain("rand");
    endtask

    initial begin
        rst = 1'b1;
        tx_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_single_event();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_gating();
        test_reset_midframe();
        test_random(800);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
